// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - synchronous FIFO controller driving an external fall-through fifomem
module sync_fifo_ctrl #(
    parameter int ADDRSIZE = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic                rd_valid,
    input  logic                rd_ready,
    input  logic                flush,
    input  logic                clear_err,
    output logic                mem_wclken,
    output logic [ADDRSIZE-1:0] mem_waddr,
    output logic                mem_wfull,
    output logic                mem_rclken,
    output logic [ADDRSIZE-1:0] mem_raddr,
    output logic [ADDRSIZE:0]   count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic [ADDRSIZE:0]   high_water
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] PTR_ONE = PW'(1);
    localparam logic [ADDRSIZE:0] AF_TH   = PW'(AF_LEVEL);
    localparam logic [ADDRSIZE:0] AE_TH   = PW'(AE_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0] high_water_q, high_water_d;
    logic              overflow_q, overflow_d;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [ADDRSIZE:0] count_next;
    logic [ADDRSIZE:0] hw_base;

    // Status decode and handshakes: from registered pointers and flush only.
    always_comb begin
        empty    = (wptr_q == rptr_q);
        full     = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                   (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
        wr_ready = !full && !flush;
        rd_valid = !empty && !flush;
        push     = wr_valid && wr_ready;
        pop      = rd_valid && rd_ready;
    end

    assign mem_wclken   = push;
    assign mem_rclken   = pop;
    assign mem_wfull    = full;
    assign mem_waddr    = wptr_q[ADDRSIZE-1:0];
    assign mem_raddr    = rptr_q[ADDRSIZE-1:0];
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);
    assign overflow     = overflow_q;
    assign high_water   = high_water_q;

    // Next-state: pointer advance, flush restart, sticky overflow, watermark.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_ONE;
            if (pop)  rptr_d = rptr_q + PTR_ONE;
        end

        // A clear in the same cycle as an overflowing write leaves the flag low.
        if (clear_err)
            overflow_d = 1'b0;
        else if (wr_valid && full)
            overflow_d = 1'b1;

        count_next   = wptr_d - rptr_d;
        hw_base      = clear_err ? count : high_water_q;
        high_water_d = (count_next > hw_base) ? count_next : hw_base;
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            overflow_q   <= 1'b0;
            high_water_q <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            overflow_q   <= overflow_d;
            high_water_q <= high_water_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl
module tb_sync_fifo_ctrl;

    localparam int AS    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, wr_valid, rd_ready, flush, clear_err;
    logic          wr_ready, rd_valid, mem_wclken, mem_wfull, mem_rclken;
    logic [AS-1:0] mem_waddr, mem_raddr;
    logic [AS:0]   count, high_water;
    logic          almost_full, almost_empty, overflow;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.ADDRSIZE(AS), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .flush(flush), .clear_err(clear_err),
        .mem_wclken(mem_wclken), .mem_waddr(mem_waddr), .mem_wfull(mem_wfull),
        .mem_rclken(mem_rclken), .mem_raddr(mem_raddr), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .high_water(high_water)
    );

    int total = 0;
    int bad   = 0;

    // Bench-side fifomem and the reference model (queue of stored words).
    logic [7:0] mem [DEPTH];
    logic [7:0] wdata;
    logic [7:0] q[$];
    int         wcnt, rcnt, m_hw;
    bit         m_ovf;

    typedef struct packed {
        logic [7:0] n;
        logic       rst, wv, rr, fl, ce;
        logic [7:0] c;
        logic       wr, rv, o;
        logic [7:0] hw;
        logic       af, ae;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];
    vec_t cur;
    bit   tbl_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcnt = 0; rcnt = 0; m_hw = 0; m_ovf = 0;
    endtask

    // One clock: check outputs at negedge against the model, update at posedge.
    task automatic cycle();
        int         sz, base;
        bit         full, e_wr, e_rv, e_push, e_pop;
        logic       d_wclken;
        logic [AS-1:0] d_waddr;
        @(negedge clk);
        sz     = q.size();
        full   = (sz == DEPTH);
        e_wr   = !full && !flush;
        e_rv   = (sz != 0) && !flush;
        e_push = wr_valid && e_wr;
        e_pop  = rd_ready && e_rv;
        chk("wr_ready",     wr_ready,     e_wr);
        chk("rd_valid",     rd_valid,     e_rv);
        chk("mem_wclken",   mem_wclken,   e_push);
        chk("mem_rclken",   mem_rclken,   e_pop);
        chk("mem_wfull",    mem_wfull,    full);
        chk("count",        count,        sz);
        chk("almost_full",  almost_full,  sz >= 12);
        chk("almost_empty", almost_empty, sz <= 2);
        chk("overflow",     overflow,     m_ovf);
        chk("high_water",   high_water,   m_hw);
        chk("mem_waddr",    mem_waddr,    wcnt % DEPTH);
        chk("mem_raddr",    mem_raddr,    rcnt % DEPTH);
        if (e_pop && mem_rclken === 1'b1)
            chk("rdata", mem[mem_raddr], q[0]);
        if (tbl_chk) begin
            chk("tbl_count",      count,        cur.c);
            chk("tbl_wr_ready",   wr_ready,     cur.wr);
            chk("tbl_rd_valid",   rd_valid,     cur.rv);
            chk("tbl_overflow",   overflow,     cur.o);
            chk("tbl_high_water", high_water,   cur.hw);
            chk("tbl_af",         almost_full,  cur.af);
            chk("tbl_ae",         almost_empty, cur.ae);
        end
        d_wclken = mem_wclken;
        d_waddr  = mem_waddr;
        @(posedge clk);
        if (d_wclken === 1'b1) mem[d_waddr] = wdata;
        if (reset) begin
            model_reset();
        end else begin
            if (clear_err)              m_ovf = 0;
            else if (wr_valid && full)  m_ovf = 1;
            if (flush) begin
                q.delete(); wcnt = 0; rcnt = 0;
            end else begin
                if (e_pop)  begin void'(q.pop_front()); rcnt++; end
                if (e_push) begin q.push_back(wdata); wcnt++; end
            end
            base = clear_err ? sz : m_hw;
            m_hw = (q.size() > base) ? q.size() : base;
        end
        #1;
    endtask

    task automatic set_in(input bit r, input bit wv, input bit rr, input bit fl, input bit ce);
        reset = r; wr_valid = wv; rd_ready = rr; flush = fl; clear_err = ce;
        wdata = 8'($urandom);
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_reset();

        //          n  rst wv rr fl ce  c  wr rv o  hw af ae
        tbl[0]  = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd0,  1'b1,1'b0,1'b0, 8'd0,  1'b0,1'b1};
        tbl[1]  = '{8'd16, 1'b0,1'b1,1'b0,1'b0,1'b0, 8'd15, 1'b1,1'b1,1'b0, 8'd15, 1'b1,1'b0};
        tbl[2]  = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd16, 1'b0,1'b1,1'b0, 8'd16, 1'b1,1'b0};
        tbl[3]  = '{8'd1,  1'b0,1'b1,1'b0,1'b0,1'b0, 8'd16, 1'b0,1'b1,1'b0, 8'd16, 1'b1,1'b0};
        tbl[4]  = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd16, 1'b0,1'b1,1'b1, 8'd16, 1'b1,1'b0};
        tbl[5]  = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b1, 8'd16, 1'b0,1'b1,1'b1, 8'd16, 1'b1,1'b0};
        tbl[6]  = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd16, 1'b0,1'b1,1'b0, 8'd16, 1'b1,1'b0};
        tbl[7]  = '{8'd1,  1'b0,1'b1,1'b1,1'b0,1'b0, 8'd16, 1'b0,1'b1,1'b0, 8'd16, 1'b1,1'b0};
        tbl[8]  = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd15, 1'b1,1'b1,1'b1, 8'd16, 1'b1,1'b0};
        tbl[9]  = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b1, 8'd15, 1'b1,1'b1,1'b1, 8'd16, 1'b1,1'b0};
        tbl[10] = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd15, 1'b1,1'b1,1'b0, 8'd15, 1'b1,1'b0};
        tbl[11] = '{8'd3,  1'b0,1'b0,1'b1,1'b0,1'b0, 8'd13, 1'b1,1'b1,1'b0, 8'd15, 1'b1,1'b0};
        tbl[12] = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd12, 1'b1,1'b1,1'b0, 8'd15, 1'b1,1'b0};
        tbl[13] = '{8'd1,  1'b0,1'b0,1'b1,1'b0,1'b0, 8'd12, 1'b1,1'b1,1'b0, 8'd15, 1'b1,1'b0};
        tbl[14] = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd11, 1'b1,1'b1,1'b0, 8'd15, 1'b0,1'b0};
        tbl[15] = '{8'd1,  1'b0,1'b1,1'b0,1'b1,1'b0, 8'd11, 1'b0,1'b0,1'b0, 8'd15, 1'b0,1'b0};
        tbl[16] = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd0,  1'b1,1'b0,1'b0, 8'd15, 1'b0,1'b1};
        tbl[17] = '{8'd1,  1'b0,1'b1,1'b1,1'b0,1'b0, 8'd0,  1'b1,1'b0,1'b0, 8'd15, 1'b0,1'b1};
        tbl[18] = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1,  1'b1,1'b1,1'b0, 8'd15, 1'b0,1'b1};
        tbl[19] = '{8'd2,  1'b0,1'b1,1'b0,1'b0,1'b0, 8'd2,  1'b1,1'b1,1'b0, 8'd15, 1'b0,1'b1};
        tbl[20] = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd3,  1'b1,1'b1,1'b0, 8'd15, 1'b0,1'b0};
        tbl[21] = '{8'd1,  1'b1,1'b1,1'b1,1'b0,1'b0, 8'd3,  1'b1,1'b1,1'b0, 8'd15, 1'b0,1'b0};
        tbl[22] = '{8'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 8'd0,  1'b1,1'b0,1'b0, 8'd0,  1'b0,1'b1};

        for (int i = 0; i < NV; i++) begin
            cur = tbl[i];
            for (int k = 0; k < int'(cur.n); k++) begin
                set_in(cur.rst, cur.wv, cur.rr, cur.fl, cur.ce);
                tbl_chk = (k == int'(cur.n) - 1);
                cycle();
            end
        end
        tbl_chk = 0;

        // Streaming: push every cycle, pop every cycle after the first; pointers wrap.
        for (int k = 0; k < 40; k++) begin
            set_in(0, 1, 1, 0, 0);
            cycle();
            chk("stream_count", count, 1);
        end
        set_in(0, 0, 1, 0, 0);
        cycle();
        chk("stream_drain", count, 0);

        // Flush at count 9 with a push offered.
        for (int k = 0; k < 9; k++) begin
            set_in(0, 1, 0, 0, 0);
            cycle();
        end
        chk("pre_flush_count", count, 9);
        set_in(0, 1, 0, 1, 0);
        cycle();
        chk("flush_count", count, 0);
        chk("flush_rd_valid", rd_valid, 0);
        chk("flush_waddr", mem_waddr, 0);

        // Randomised traffic in phases of differing write/read pressure.
        for (int ph = 0; ph < 15; ph++) begin
            int wp, rp;
            wp = $urandom_range(20, 90);
            rp = $urandom_range(20, 90);
            for (int k = 0; k < 200; k++) begin
                set_in($urandom_range(0, 299) == 0,
                       $urandom_range(0, 99) < wp,
                       $urandom_range(0, 99) < rp,
                       $urandom_range(0, 99) < 2,
                       $urandom_range(0, 99) < 3);
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, meaning fifomem address width; depth = 2^ADDRSIZE.
REQ-002 SHALL have parameter AF_LEVEL, default 12, meaning almost_full threshold in words.
REQ-003 SHALL have parameter AE_LEVEL, default 2, meaning almost_empty threshold in words.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_valid  in  1  producer offers a word.
REQ-007 wr_ready  out  1  controller accepts a word.
REQ-008 rd_valid  out  1  word available at memory rdata (fall-through).
REQ-009 rd_ready  in  1  consumer takes the word.
REQ-010 flush  in  1  discard all contents.
REQ-011 clear_err  in  1  clear overflow flag and high watermark.
REQ-012 mem_wclken  out  1  fifomem write enable.
REQ-013 mem_waddr  out  ADDRSIZE  fifomem write address.
REQ-014 mem_wfull  out  1  fifomem write guard (= full).
REQ-015 mem_rclken  out  1  fifomem read enable (= pop).
REQ-016 mem_raddr  out  ADDRSIZE  fifomem read address.
REQ-017 count  out  ADDRSIZE+1  stored words, 0..2^ADDRSIZE.
REQ-018 almost_full, almost_empty  out  1 each  threshold flags.
REQ-019 overflow  out  1  sticky: write attempted while full.
REQ-020 high_water  out  ADDRSIZE+1  max count since reset/clear.

Function
REQ-021 wptr, rptr SHALL be ADDRSIZE+1-bit registers, incrementing mod 2^(ADDRSIZE+1); memory addresses = low ADDRSIZE bits.
REQ-022 empty SHALL equal (wptr == rptr); full SHALL equal (MSBs differ, low bits equal); both decoded from registered pointers only.
REQ-023 wr_ready = !full && !flush; rd_valid = !empty && !flush; combinational from registers and flush only, never from wr_valid/rd_ready.
REQ-024 push = wr_valid && wr_ready; pop = rd_valid && rd_ready; mem_wclken = push; mem_rclken = pop; same cycle, zero latency.
REQ-025 Push SHALL increment wptr at the edge; pop SHALL increment rptr at the edge.
REQ-026 A pushed word SHALL be visible (rd_valid high, mem_raddr pointing at it) on the cycle after push; no same-cycle bypass into empty.
REQ-027 count SHALL be +1 on push only, -1 on pop only, unchanged on both or neither; count SHALL always equal wptr - rptr.
REQ-028 Full with pop and wr_valid: pop completes, push refused; wr_ready rises next cycle.
REQ-029 Empty with wr_valid and rd_ready: push completes, no pop.
REQ-030 almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL); combinational from count.
REQ-031 overflow SHALL set at the edge after any cycle with wr_valid && full, and hold until clear_err or reset.
REQ-032 high_water SHALL load the next count whenever it exceeds high_water.
REQ-033 flush SHALL zero wptr, rptr and count at the edge and suppress push/pop that cycle; overflow and high_water unaffected.
REQ-034 clear_err SHALL clear overflow and load high_water with the current count at the edge; if overflow sets the same cycle, clear wins.
REQ-035 Priority: reset > flush > normal operation.
REQ-036 Pointer wrap past 2^(ADDRSIZE+1)-1 to 0 SHALL not disturb flags or count.

Reset
REQ-037 On reset: wptr=rptr=0, count=0, overflow=0, high_water=0.
REQ-038 Hence out of reset: wr_ready=1, rd_valid=0, mem_wclken=0, mem_rclken=0, almost_empty=1, almost_full=0, mem_waddr=mem_raddr=0.
REQ-039 Reset mid-operation SHALL discard contents regardless of push/pop/flush that cycle; memory contents need not be cleared.

Verification
REQ-040 Fill: 16 pushes, rd_ready=0 -> count 16, wr_ready=0, almost_full from count 12, high_water=16, mem_wfull=1.
REQ-041 Overflow: full, wr_valid 1 cycle -> no mem_wclken, overflow=1 next cycle; clear_err -> overflow=0, high_water=16.
REQ-042 Full, simultaneous push+pop -> only pop, count 15, wr_ready=1 next cycle.
REQ-043 Empty, push with rd_ready=1 -> rd_valid=0 that cycle, 1 next cycle, mem_raddr=0, data read back in order.
REQ-044 Stream 40 words, push/pop every cycle after first -> count stays 1, pointers wrap, all 40 data in order.
REQ-045 Flush at count 9 with push asserted -> count 0, rd_valid=0, push ignored; reset mid-stream -> REQ-038 values next cycle.
